i2c_arb: RTL and testbench

Round-robin arbiter and sequencer sharing one i2c_ctrl instance among NUM_REQ requesters.
- Each requester presents a byte address (bit 0 = R/nW, I2C convention) and write data.
- The arbiter grants one requester and launches the transaction on i2c_ctrl.
- It waits for busy to complete, returns read data and pulses done to the owner.
- Sits between on-chip clients (config FSMs, CPU bridge) and i2c_ctrl; the top level owns the tristate on the i2c_ctrl data bus.

---
 rtl/i2c_arb_pkg.sv | 26 ++
 rtl/i2c_arb_rr_pick.sv | 40 ++++
 rtl/i2c_arb.sv | 166 ++++++++++++++++
 tb/tb_i2c_arb.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// ---------------------------------------------------------------------------
// i2c_arb_pkg
// Shared types and constants for the i2c_arb round-robin arbiter.
//   state_t    : sequencer states (IDLE, LAUNCH, XFER, FINISH)
//   I2C_BYTE_W : width of an I2C address/data byte
//   I2C_RW_BIT : position of the R/nW flag inside the address byte
//   ptr_w()    : width of the round-robin pointer for a given requester count
// ---------------------------------------------------------------------------
package i2c_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      XFER   = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam int I2C_BYTE_W = 8;
   localparam int I2C_RW_BIT = 0;

   // At least one bit even for degenerate counts so the pointer never collapses.
   function automatic int ptr_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/i2c_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// i2c_arb_rr_pick
// Combinational round-robin picker: returns the first set request bit
// searching upward from i_ptr+1, wrapping modulo NUM_REQ.
//   i_req  : request vector
//   i_ptr  : index of the previous owner
//   o_gnt  : one-hot pick (all zero when no request is set)
//   o_idx  : index of the pick (0 when no request is set)
// ---------------------------------------------------------------------------
module i2c_arb_rr_pick
   import i2c_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int PW     = ptr_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PW-1:0]      i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [PW-1:0]      o_idx
);

   always_comb begin
      int  w_j;
      logic w_found;
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_j     = 0;
      // k runs 1..NUM_REQ so the previous owner is examined last.
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_j = (int'(i_ptr) + k) % NUM_REQ;
         if (!w_found && i_req[w_j]) begin
            w_found      = 1'b1;
            o_gnt[w_j]   = 1'b1;
            o_idx        = PW'(w_j);
         end
      end
   end

endmodule

// File: rtl/i2c_arb.sv
// ---------------------------------------------------------------------------
// i2c_arb
// Round-robin arbiter/sequencer sharing one i2c_ctrl among NUM_REQ clients.
// Grants a requester, launches its byte on i2c_ctrl, waits for busy to fall,
// returns read data and pulses done to the owner.
//
// Optional feature (macro I2C_ARB_LAUNCH_TMO_EN): abort the launch if
// ctrl_busy has not risen within LAUNCH_TMO cycles, pulsing done with err.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   req/req_addr/req_wdata : per-requester level request, address, write byte
//   gnt, done           : one-hot grant, one-cycle completion pulse
//   err                 : launch-timeout abort pulse (0 without the feature)
//   rdata               : last read byte, updated in the done cycle of reads
//   ctrl_en             : active-low launch strobe to i2c_ctrl
//   ctrl_busy           : i2c_ctrl busy
//   ctrl_addr/ctrl_wdata: byte presented to i2c_ctrl
//   ctrl_data_oe        : tristate enable for the data bus (writes only)
//   ctrl_rdata          : data bus as sampled from i2c_ctrl
// ---------------------------------------------------------------------------
module i2c_arb
   import i2c_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int LAUNCH_TMO = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*I2C_BYTE_W-1:0] req_addr,
   input  logic [NUM_REQ*I2C_BYTE_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            done,
   output logic                          err,
   output logic [I2C_BYTE_W-1:0]         rdata,
   output logic                          ctrl_en,
   input  logic                          ctrl_busy,
   output logic [I2C_BYTE_W-1:0]         ctrl_addr,
   output logic [I2C_BYTE_W-1:0]         ctrl_wdata,
   output logic                          ctrl_data_oe,
   input  logic [I2C_BYTE_W-1:0]         ctrl_rdata
);

   localparam int PW = ptr_w(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || LAUNCH_TMO < 1) begin : g_bad_param
      $error("i2c_arb: NUM_REQ must be 2..8 and LAUNCH_TMO >= 1");
   end

   state_t                  r_state;
   logic [PW-1:0]           r_ptr;
   logic [NUM_REQ-1:0]      r_gnt;
   logic [NUM_REQ-1:0]      r_done;
   logic [I2C_BYTE_W-1:0]   r_rdata;
   logic                    r_ctrl_en;
   logic [I2C_BYTE_W-1:0]   r_ctrl_addr;
   logic [I2C_BYTE_W-1:0]   r_ctrl_wdata;
   logic                    r_ctrl_data_oe;

   logic [NUM_REQ-1:0]      w_gnt;
   logic [PW-1:0]           w_idx;
   logic [I2C_BYTE_W-1:0]   w_sel_addr;
   logic [I2C_BYTE_W-1:0]   w_sel_wdata;

   i2c_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .i_req (req),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx)
   );

   // Byte slices of the candidate requester; {idx,3'b000} == idx*8.
   assign w_sel_addr  = req_addr [{w_idx, 3'b000} +: I2C_BYTE_W];
   assign w_sel_wdata = req_wdata[{w_idx, 3'b000} +: I2C_BYTE_W];

`ifdef I2C_ARB_LAUNCH_TMO_EN
   localparam int CW = $clog2(LAUNCH_TMO + 1);
   logic [CW-1:0] r_tmo_cnt;
   logic          r_err;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= IDLE;
         r_ptr          <= PW'(NUM_REQ - 1);
         r_gnt          <= '0;
         r_done         <= '0;
         r_rdata        <= '0;
         r_ctrl_en      <= 1'b1;
         r_ctrl_addr    <= 8'hFF;
         r_ctrl_wdata   <= '0;
         r_ctrl_data_oe <= 1'b0;
`ifdef I2C_ARB_LAUNCH_TMO_EN
         r_tmo_cnt      <= '0;
         r_err          <= 1'b0;
`endif
      end else begin
         r_done <= '0;
`ifdef I2C_ARB_LAUNCH_TMO_EN
         r_err  <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (|req) begin
                  r_gnt          <= w_gnt;
                  r_ptr          <= w_idx;
                  r_ctrl_addr    <= w_sel_addr;
                  r_ctrl_wdata   <= w_sel_wdata;
                  r_ctrl_data_oe <= ~w_sel_addr[I2C_RW_BIT];
                  r_ctrl_en      <= 1'b0;
                  r_state        <= LAUNCH;
`ifdef I2C_ARB_LAUNCH_TMO_EN
                  r_tmo_cnt      <= '0;
`endif
               end
            end
            LAUNCH: begin
               if (ctrl_busy) begin
                  r_ctrl_en <= 1'b1;
                  r_state   <= XFER;
               end
`ifdef I2C_ARB_LAUNCH_TMO_EN
               // Counter value LAUNCH_TMO-1 means this is the last allowed cycle.
               else if (r_tmo_cnt == CW'(LAUNCH_TMO - 1)) begin
                  r_ctrl_en <= 1'b1;
                  r_done    <= r_gnt;
                  r_err     <= 1'b1;
                  r_state   <= FINISH;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
               end
`endif
            end
            XFER: begin
               if (!ctrl_busy) begin
                  if (r_ctrl_addr[I2C_RW_BIT]) r_rdata <= ctrl_rdata;
                  // r_gnt is the one-hot of r_ptr, so it is the done vector.
                  r_done  <= r_gnt;
                  r_state <= FINISH;
               end
            end
            FINISH: begin
               r_gnt          <= '0;
               r_ctrl_data_oe <= 1'b0;
               r_state        <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign gnt          = r_gnt;
   assign done         = r_done;
   assign rdata        = r_rdata;
   assign ctrl_en      = r_ctrl_en;
   assign ctrl_addr    = r_ctrl_addr;
   assign ctrl_wdata   = r_ctrl_wdata;
   assign ctrl_data_oe = r_ctrl_data_oe;
`ifdef I2C_ARB_LAUNCH_TMO_EN
   assign err          = r_err;
`else
   assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_arb.sv
// ---------------------------------------------------------------------------
// tb_i2c_arb
// Directed bench for i2c_arb (NUM_REQ=4, LAUNCH_TMO=8) with a small
// behavioural i2c_ctrl: busy rises 3 cycles after ctrl_en=0 and stays high
// for 20 cycles, unless m_never holds it low.
// ---------------------------------------------------------------------------
module tb_i2c_arb;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req;
   logic [N*8-1:0] req_addr;
   logic [N*8-1:0] req_wdata;
   logic [N-1:0]  gnt;
   logic [N-1:0]  done;
   logic          err;
   logic [7:0]    rdata;
   logic          ctrl_en;
   logic          ctrl_busy;
   logic [7:0]    ctrl_addr;
   logic [7:0]    ctrl_wdata;
   logic          ctrl_data_oe;
   logic [7:0]    ctrl_rdata;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   int m_st  = 0;
   int m_cnt = 0;
   bit m_never = 1'b0;

   i2c_arb #(.NUM_REQ(N), .LAUNCH_TMO(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .gnt          (gnt),
      .done         (done),
      .err          (err),
      .rdata        (rdata),
      .ctrl_en      (ctrl_en),
      .ctrl_busy    (ctrl_busy),
      .ctrl_addr    (ctrl_addr),
      .ctrl_wdata   (ctrl_wdata),
      .ctrl_data_oe (ctrl_data_oe),
      .ctrl_rdata   (ctrl_rdata)
   );

   always #5 clk = ~clk;

   // i2c_ctrl stand-in, updated on the falling edge so the DUT sees stable busy.
   always @(negedge clk) begin
      if (rst) begin
         ctrl_busy = 1'b0;
         m_st      = 0;
         m_cnt     = 0;
      end else begin
         case (m_st)
            0: if (!ctrl_en && !m_never) begin m_st = 1; m_cnt = 0; end
            1: begin
               m_cnt++;
               if (m_cnt == 3) begin ctrl_busy = 1'b1; m_cnt = 0; m_st = 2; end
            end
            2: begin
               m_cnt++;
               if (m_cnt == 20) begin ctrl_busy = 1'b0; m_st = 0; end
            end
            default: m_st = 0;
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string tag, input int limit);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (done == '0 && n < limit);
      chk({tag, "_done_seen"}, 32'(|done), 1);
   endtask

   task automatic wait_busy(input string tag, input int limit);
      int n;
      n = 0;
      while (!ctrl_busy && n < limit) begin
         step();
         n++;
      end
      chk({tag, "_busy_seen"}, 32'(ctrl_busy), 1);
   endtask

   int order [5] = '{0, 1, 2, 3, 0};

   initial begin
      rst = 1'b1; req = '0; req_addr = '0; req_wdata = '0; ctrl_rdata = '0;
      repeat (3) step();

      // Reset state
      chk("rst_gnt",   32'(gnt), 0);
      chk("rst_done",  32'(done), 0);
      chk("rst_err",   32'(err), 0);
      chk("rst_rdata", 32'(rdata), 0);
      chk("rst_en",    32'(ctrl_en), 1);
      chk("rst_addr",  32'(ctrl_addr), 'hFF);
      chk("rst_wdata", 32'(ctrl_wdata), 0);
      chk("rst_oe",    32'(ctrl_data_oe), 0);

      // Single write from requester 0
      @(negedge clk);
      rst = 1'b0;
      req = 4'b0001; req_addr[7:0] = 8'hA0; req_wdata[7:0] = 8'h55;
      step();
      chk("wr_gnt",   32'(gnt), 'h1);
      chk("wr_addr",  32'(ctrl_addr), 'hA0);
      chk("wr_wdata", 32'(ctrl_wdata), 'h55);
      chk("wr_oe",    32'(ctrl_data_oe), 1);
      chk("wr_en",    32'(ctrl_en), 0);
      wait_done("wr", 100);
      chk("wr_done",  32'(done), 'h1);
      chk("wr_rdata", 32'(rdata), 0);
      chk("wr_err",   32'(err), 0);
      chk("wr_gnt_hold", 32'(gnt), 'h1);
      req = '0;
      step();
      chk("wr_done_clr", 32'(done), 0);
      chk("wr_gnt_clr",  32'(gnt), 0);

      // Single read from requester 2
      req_addr[23:16] = 8'hAF; ctrl_rdata = 8'h3C; req = 4'b0100;
      step();
      chk("rd_gnt",  32'(gnt), 'h4);
      chk("rd_oe",   32'(ctrl_data_oe), 0);
      chk("rd_addr", 32'(ctrl_addr), 'hAF);
      wait_done("rd", 100);
      chk("rd_done",  32'(done), 'h4);
      chk("rd_rdata", 32'(rdata), 'h3C);
      req = '0; ctrl_rdata = 8'h00;
      step();
      chk("rd_rdata_hold", 32'(rdata), 'h3C);

      // Contention: all four requesting from reset
      rst = 1'b1;
      req_addr = {8'h16, 8'h14, 8'h12, 8'h10};
      req = 4'b1111;
      step();
      @(negedge clk);
      rst = 1'b0;
      step();
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(1) << order[k]);
         chk($sformatf("rr%0d_onehot", k), 32'($onehot(gnt)), 1);
         chk($sformatf("rr%0d_addr", k), 32'(ctrl_addr), 'h10 + 2 * order[k]);
         wait_done($sformatf("rr%0d", k), 100);
         chk($sformatf("rr%0d_done", k), 32'(done), 32'(1) << order[k]);
         if (k == 4) req = '0;
         step();
         chk($sformatf("rr%0d_idle", k), 32'(gnt), 0);
         if (k < 4) step();
      end

      // Drop during XFER, then round robin from owner 1
      req = 4'b0010;
      step();
      chk("drop_gnt", 32'(gnt), 'h2);
      wait_busy("drop", 20);
      req = '0;
      wait_done("drop", 100);
      chk("drop_done", 32'(done), 'h2);
      req = 4'b1010;
      step();
      chk("rr3_idle", 32'(gnt), 0);
      step();
      chk("rr3_gnt", 32'(gnt), 'h8);
      wait_done("rr3", 100);
      chk("rr3_done", 32'(done), 'h8);
      step();
      step();
      chk("rr1_gnt", 32'(gnt), 'h2);
      wait_done("rr1", 100);
      chk("rr1_done", 32'(done), 'h2);
      req = '0;
      step();

      // Reset in the middle of XFER
      req = 4'b0001;
      step();
      chk("mid_gnt", 32'(gnt), 'h1);
      wait_busy("mid", 20);
      step();
      rst = 1'b1;
      #1;
      chk("mid_rst_gnt",  32'(gnt), 0);
      chk("mid_rst_en",   32'(ctrl_en), 1);
      chk("mid_rst_addr", 32'(ctrl_addr), 'hFF);
      chk("mid_rst_oe",   32'(ctrl_data_oe), 0);
      chk("mid_rst_done", 32'(done), 0);
      step();
      chk("mid_rst_done2", 32'(done), 0);
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("mid_regnt", 32'(gnt), 'h1);
      wait_done("mid_re", 100);
      chk("mid_re_done", 32'(done), 'h1);
      req = '0;
      step();

`ifdef I2C_ARB_LAUNCH_TMO_EN
      // Launch timeout: busy never rises
      begin
         int n_en;
         m_never = 1'b1;
         req = 4'b0100;
         step();
         chk("tmo_gnt", 32'(gnt), 'h4);
         n_en = 0;
         if (!ctrl_en) n_en = 1;
         for (int c = 0; c < 50; c++) begin
            step();
            if (ctrl_en) break;
            n_en++;
         end
         chk("tmo_en_cycles", 32'(n_en), 8);
         chk("tmo_done", 32'(done), 'h4);
         chk("tmo_err",  32'(err), 1);
         req = '0;
         step();
         chk("tmo_err_clr", 32'(err), 0);
         chk("tmo_gnt_clr", 32'(gnt), 0);
         m_never = 1'b0;
         req = 4'b0001;
         step();
         chk("tmo_after_gnt", 32'(gnt), 'h1);
         wait_done("tmo_after", 100);
         chk("tmo_after_err", 32'(err), 0);
         req = '0;
         step();
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Global time limit so the run can never hang.
   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
